// File: rtl/life_renderer.sv
// Toroidal Game of Life grid rendered as 32x32-pixel cells on a 640x480 raster.
// One generation is computed cell-serially during vertical blanking, then committed.
`timescale 1ns/1ps
module life_renderer #(
    parameter int               COLS           = 20,
    parameter int               ROWS           = 15,
    parameter int               FRAMES_PER_GEN = 8,
    parameter logic [COLS*ROWS-1:0] SEED       = (COLS*ROWS)'(300'h7 << 149),
    parameter logic [5:0]       ALIVE_RGB      = 6'b001100,
    parameter logic [5:0]       DEAD_RGB       = 6'b000001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       run,
    input  logic       step,
    output logic [5:0] rgb,
    output logic       busy,
    output logic [7:0] gen_count
);

    localparam int NCELLS = COLS * ROWS;
    localparam int IW     = $clog2(NCELLS);
    localparam int RW     = $clog2(ROWS);
    localparam int CW     = $clog2(COLS);
    localparam int FW     = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

    localparam logic [9:0] COLS10 = 10'(COLS);
    localparam logic [9:0] GRID_W = 10'(COLS * 32);
    localparam logic [9:0] GRID_H = 10'(ROWS * 32);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_COMMIT
    } state_e;

    state_e              state_q, state_d;
    logic [NCELLS-1:0]   cur_q, cur_d;
    logic [NCELLS-1:0]   nxt_q, nxt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [RW-1:0]       row_q, row_d;
    logic [CW-1:0]       col_q, col_d;
    logic [FW-1:0]       frame_cnt_q, frame_cnt_d;
    logic                step_pending_q, step_pending_d;
    logic [7:0]          gen_q, gen_d;
    logic [5:0]          rgb_q, rgb_d;

    logic                frame_tick;
    logic                start;
    logic                last_cell;
    logic [RW-1:0]       row_m, row_p;
    logic [CW-1:0]       col_m, col_p;
    logic [3:0]          n_sum;
    logic                new_cell;
    logic                visible;
    logic                in_grid;
    logic [IW-1:0]       pix_idx;

    function automatic logic [IW-1:0] cell_idx(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return IW'(int'(r) * COLS + int'(c));
    endfunction

    assign frame_tick = (hpos == 10'd0) && (vpos == 10'd480);
    assign start      = (state_q == S_IDLE) && frame_tick &&
                        ((run && (frame_cnt_q == FW'(FRAMES_PER_GEN - 1))) || step_pending_q);
    assign last_cell  = (idx_q == IW'(NCELLS - 1));

    // Neighbourhood of the cell under evaluation, wrapping at every grid edge.
    always_comb begin
        row_m = (row_q == '0) ? RW'(ROWS - 1) : row_q - RW'(1);
        row_p = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        col_m = (col_q == '0) ? CW'(COLS - 1) : col_q - CW'(1);
        col_p = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
        n_sum = 4'(cur_q[cell_idx(row_m, col_m)]) + 4'(cur_q[cell_idx(row_m, col_q)]) +
                4'(cur_q[cell_idx(row_m, col_p)]) + 4'(cur_q[cell_idx(row_q, col_m)]) +
                4'(cur_q[cell_idx(row_q, col_p)]) + 4'(cur_q[cell_idx(row_p, col_m)]) +
                4'(cur_q[cell_idx(row_p, col_q)]) + 4'(cur_q[cell_idx(row_p, col_p)]);
        new_cell = (n_sum == 4'd3) || (cur_q[idx_q] && (n_sum == 4'd2));
    end

    // Pixel lookup always reads the committed grid, so a generation in flight never tears.
    always_comb begin
        visible = (hpos < 10'd640) && (vpos < 10'd480);
        in_grid = (hpos < GRID_W) && (vpos < GRID_H);
        pix_idx = IW'({5'd0, vpos[9:5]} * COLS10 + {5'd0, hpos[9:5]});
        if (!visible) begin
            rgb_d = 6'b0;
        end else if (in_grid && cur_q[pix_idx]) begin
            rgb_d = ALIVE_RGB;
        end else begin
            rgb_d = DEAD_RGB;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_COMPUTE;
            S_COMPUTE: if (last_cell) state_d = S_COMMIT;
            S_COMMIT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Datapath next-state.
    // NOTE: every signal written here is defaulted first so no latch is inferred.
    always_comb begin
        cur_d          = cur_q;
        nxt_d          = nxt_q;
        idx_d          = '0;
        row_d          = '0;
        col_d          = '0;
        gen_d          = gen_q;
        frame_cnt_d    = frame_cnt_q;
        step_pending_d = (step_pending_q && !start) || step;

        if (frame_tick) begin
            frame_cnt_d = (frame_cnt_q == FW'(FRAMES_PER_GEN - 1)) ? '0 : frame_cnt_q + FW'(1);
        end

        case (state_q)
            S_COMPUTE: begin
                nxt_d[idx_q] = new_cell;
                idx_d        = idx_q + IW'(1);
                if (col_q == CW'(COLS - 1)) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                    row_d = row_q;
                end
            end
            S_COMMIT: begin
                cur_d = nxt_q;
                gen_d = gen_q + 8'd1;
            end
            default: ;
        endcase
    end

    // NOTE: registers use <= so every flop samples pre-edge values; cur/nxt are plain
    // flops rather than RAM, which is what makes loading the seed on reset legal.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q          <= SEED;
            nxt_q          <= '0;
            idx_q          <= '0;
            row_q          <= '0;
            col_q          <= '0;
            frame_cnt_q    <= '0;
            step_pending_q <= 1'b0;
            gen_q          <= 8'd0;
            rgb_q          <= 6'b0;
        end else begin
            cur_q          <= cur_d;
            nxt_q          <= nxt_d;
            idx_q          <= idx_d;
            row_q          <= row_d;
            col_q          <= col_d;
            frame_cnt_q    <= frame_cnt_d;
            step_pending_q <= step_pending_d;
            gen_q          <= gen_d;
            rgb_q          <= rgb_d;
        end
    end

    assign rgb       = rgb_q;
    assign gen_count = gen_q;

endmodule

// File: tb/tb_life_renderer.sv
// Scoreboard bench for life_renderer: the stimulus thread queues expected values,
// a negedge monitor pops and compares them one cycle after each request.
`timescale 1ns/1ps
module tb_life_renderer;

    localparam logic [5:0] ALIVE = 6'b001100;
    localparam logic [5:0] DEAD  = 6'b000001;

    // Blinker: horizontal row 7 cols 9..11, vertical col 10 rows 6..8.
    localparam logic [299:0] BLINK_H = (300'd1 << (7*20+9)) | (300'd1 << (7*20+10)) | (300'd1 << (7*20+11));
    localparam logic [299:0] BLINK_V = (300'd1 << (6*20+10)) | (300'd1 << (7*20+10)) | (300'd1 << (8*20+10));
    // Down-right glider at the origin, after 4 gens (+1,+1), after 60 gens (+15 rows == 0, +15 cols).
    localparam logic [299:0] GLIDER_0  = (300'd1 << (0*20+1))  | (300'd1 << (1*20+2))  | (300'd1 << (2*20+0)) |
                                         (300'd1 << (2*20+1))  | (300'd1 << (2*20+2));
    localparam logic [299:0] GLIDER_4  = (300'd1 << (1*20+2))  | (300'd1 << (2*20+3))  | (300'd1 << (3*20+1)) |
                                         (300'd1 << (3*20+2))  | (300'd1 << (3*20+3));
    localparam logic [299:0] GLIDER_60 = (300'd1 << (0*20+16)) | (300'd1 << (1*20+17)) | (300'd1 << (2*20+15)) |
                                         (300'd1 << (2*20+16)) | (300'd1 << (2*20+17));
    // 2x2 block split across both wrap seams.
    localparam logic [299:0] BLOCK_W = (300'd1 << (0*20+0))  | (300'd1 << (0*20+19)) |
                                       (300'd1 << (14*20+0)) | (300'd1 << (14*20+19));

    typedef enum {K_RGB_M, K_RGB_G, K_RGB_B, K_GEN_M, K_BUSY_M, K_BLEN_M, K_GEN_G, K_GEN_S} kind_e;
    typedef struct {
        kind_e      kind;
        logic [8:0] exp;
        string      name;
    } item_t;

    logic       clk = 1'b0;
    logic [9:0] hpos, vpos;
    logic       reset_m, run_m, step_m;
    logic       reset_a, run_a, step_a;
    logic       reset_s, run_s, step_s;
    logic [5:0] rgb_m, rgb_g, rgb_b, rgb_s;
    logic       busy_m, busy_g, busy_b, busy_s;
    logic [7:0] gen_m, gen_g, gen_b, gen_s;

    item_t      sb[$];
    item_t      mon_it;
    logic [8:0] mon_act;
    logic       req   = 1'b0;
    logic       req_q = 1'b0;
    int         checks   = 0;
    int         errors   = 0;
    int         busy_run = 0;
    int         busy_len = 0;

    always #5 clk = ~clk;

    life_renderer #(.SEED(BLINK_H)) u_main (
        .clk(clk), .reset(reset_m), .hpos(hpos), .vpos(vpos), .run(run_m), .step(step_m),
        .rgb(rgb_m), .busy(busy_m), .gen_count(gen_m));

    life_renderer #(.SEED(GLIDER_0)) u_glider (
        .clk(clk), .reset(reset_a), .hpos(hpos), .vpos(vpos), .run(run_a), .step(step_a),
        .rgb(rgb_g), .busy(busy_g), .gen_count(gen_g));

    life_renderer #(.SEED(BLOCK_W)) u_block (
        .clk(clk), .reset(reset_a), .hpos(hpos), .vpos(vpos), .run(run_a), .step(step_a),
        .rgb(rgb_b), .busy(busy_b), .gen_count(gen_b));

    life_renderer #(.COLS(4), .ROWS(3), .FRAMES_PER_GEN(1), .SEED(12'h070)) u_small (
        .clk(clk), .reset(reset_s), .hpos(hpos), .vpos(vpos), .run(run_s), .step(step_s),
        .rgb(rgb_s), .busy(busy_s), .gen_count(gen_s));

    always @(posedge clk) req_q <= req;

    // Length of the most recent busy pulse on the main instance.
    always @(negedge clk) begin
        if (busy_m) begin
            busy_run = busy_run + 1;
        end else if (busy_run != 0) begin
            busy_len = busy_run;
            busy_run = 0;
        end
    end

    always @(negedge clk) begin
        if (req_q) begin
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL scoreboard_empty: got a response with no expected entry");
            end else begin
                mon_it = sb.pop_front();
                case (mon_it.kind)
                    K_RGB_M:  mon_act = {3'b0, rgb_m};
                    K_RGB_G:  mon_act = {3'b0, rgb_g};
                    K_RGB_B:  mon_act = {3'b0, rgb_b};
                    K_GEN_M:  mon_act = {1'b0, gen_m};
                    K_BUSY_M: mon_act = {8'b0, busy_m};
                    K_BLEN_M: mon_act = 9'(busy_len);
                    K_GEN_G:  mon_act = {1'b0, gen_g};
                    K_GEN_S:  mon_act = {1'b0, gen_s};
                    default:  mon_act = 9'h1ff;
                endcase
                checks = checks + 1;
                if (mon_act !== mon_it.exp) begin
                    errors = errors + 1;
                    $display("FAIL %s: got %0d expected %0d", mon_it.name, mon_act, mon_it.exp);
                end
            end
        end
    end

    // Queue an expectation for the output produced by the inputs currently driven.
    task automatic check(input kind_e k, input logic [8:0] e, input string nm);
        item_t it;
        it.kind = k;
        it.exp  = e;
        it.name = nm;
        sb.push_back(it);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        hpos = 10'd0;
        vpos = 10'd480;
        @(posedge clk); #1;
        hpos = 10'd700;
        vpos = 10'd500;
    endtask

    task automatic pulse_step_m();
        step_m = 1'b1;
        @(posedge clk); #1;
        step_m = 1'b0;
    endtask

    task automatic probe_grid(input kind_e k, input logic [299:0] g, input string tag);
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 20; c++) begin
                hpos = 10'(c * 32 + 16);
                vpos = 10'(r * 32 + 16);
                check(k, g[r*20+c] ? {3'b0, ALIVE} : {3'b0, DEAD}, $sformatf("%s_r%0dc%0d", tag, r, c));
            end
        end
        hpos = 10'd700;
        vpos = 10'd500;
    endtask

    initial begin
        #5_000_000;
        errors = errors + 1;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        hpos = 10'd700; vpos = 10'd500;
        reset_m = 1'b1; run_m = 1'b0; step_m = 1'b0;
        reset_a = 1'b1; run_a = 1'b0; step_a = 1'b0;
        reset_s = 1'b1; run_s = 1'b0; step_s = 1'b0;
        @(posedge clk); #1;

        // Reset state and basic rendering of the seed.
        hpos = 10'd320; vpos = 10'd240;
        check(K_RGB_M, 9'd0, "rgb_during_reset");
        reset_m = 1'b0; reset_a = 1'b0; reset_s = 1'b0;
        check(K_GEN_M,  9'd0, "gen_after_reset");
        check(K_BUSY_M, 9'd0, "busy_after_reset");
        check(K_RGB_M, {3'b0, ALIVE}, "rgb_center_alive");
        hpos = 10'd640; vpos = 10'd240; check(K_RGB_M, 9'd0, "rgb_hpos_640");
        hpos = 10'd320; vpos = 10'd480; check(K_RGB_M, 9'd0, "rgb_vpos_480");
        hpos = 10'd639; vpos = 10'd479; check(K_RGB_M, {3'b0, DEAD}, "rgb_last_pixel");
        hpos = 10'd288; vpos = 10'd224; check(K_RGB_M, {3'b0, ALIVE}, "rgb_cell_first_pixel");
        hpos = 10'd287; vpos = 10'd224; check(K_RGB_M, {3'b0, DEAD}, "rgb_left_neighbour");
        probe_grid(K_RGB_M, BLINK_H, "seed");

        // Automatic generation on the 8th frame tick; run dropped mid-compute.
        run_m = 1'b1;
        repeat (7) begin tick(); idle(2); end
        check(K_GEN_M,  9'd0, "gen_before_8th_tick");
        check(K_BUSY_M, 9'd0, "busy_before_8th_tick");
        tick();
        run_m = 1'b0;
        check(K_BUSY_M, 9'd1, "busy_after_tick");
        idle(298);
        check(K_GEN_M,  9'd0, "gen_tick_plus_300");
        check(K_GEN_M,  9'd1, "gen_tick_plus_301");
        check(K_BUSY_M, 9'd0, "busy_after_commit");
        check(K_BLEN_M, 9'd301, "busy_length");
        probe_grid(K_RGB_M, BLINK_V, "gen1");

        // Single step is held until the next tick; a step during compute is served later.
        pulse_step_m(); idle(3);
        check(K_GEN_M, 9'd1, "gen_step_pending");
        tick(); idle(150);
        pulse_step_m(); idle(160);
        check(K_GEN_M, 9'd2, "gen_after_step");
        probe_grid(K_RGB_M, BLINK_H, "gen2");
        tick(); idle(305);
        check(K_GEN_M, 9'd3, "gen_step_in_compute");

        // Two pulses before one tick give one generation; pending is then clear.
        pulse_step_m(); idle(2); pulse_step_m(); idle(2);
        tick(); idle(305);
        check(K_GEN_M, 9'd4, "gen_two_pulses");
        tick(); idle(305);
        check(K_GEN_M, 9'd4, "gen_pending_cleared");
        repeat (20) begin tick(); idle(2); end
        check(K_GEN_M, 9'd4, "gen_frozen_20_frames");
        probe_grid(K_RGB_M, BLINK_H, "frozen");

        // Reset while evaluating cell 150 aborts with no partial commit.
        pulse_step_m(); tick(); idle(305);
        check(K_GEN_M, 9'd5, "gen_before_abort");
        pulse_step_m(); tick(); idle(148);
        check(K_BUSY_M, 9'd1, "busy_mid_compute");
        idle(1);
        reset_m = 1'b1;
        check(K_BUSY_M, 9'd0, "busy_after_abort");
        reset_m = 1'b0;
        check(K_GEN_M, 9'd0, "gen_after_abort");
        probe_grid(K_RGB_M, BLINK_H, "abort");

        // Glider across the row seam and block across both seams.
        for (int g = 1; g <= 60; g++) begin
            step_a = 1'b1; @(posedge clk); #1; step_a = 1'b0;
            tick(); idle(305);
            if (g == 4) begin
                probe_grid(K_RGB_B, BLOCK_W, "block4");
                probe_grid(K_RGB_G, GLIDER_4, "glider4");
            end
        end
        check(K_GEN_G, 9'd60, "glider_gen_count");
        probe_grid(K_RGB_G, GLIDER_60, "glider60");

        // Generation counter wraps 255 -> 0 on a small grid.
        check(K_GEN_S, 9'd0, "small_gen_idle");
        run_s = 1'b1;
        repeat (255) begin tick(); idle(15); end
        check(K_GEN_S, 9'd255, "small_gen_255");
        tick(); idle(15);
        check(K_GEN_S, 9'd0, "small_gen_wrap");
        run_s = 1'b0;

        idle(3);
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
